bias_load_ctrl: RTL and testbench
=================================

# bias_load_ctrl

Sequencer for the per-layer bias buffer. Accepts bias words from the AXI input stream and writes them into the 64-bit write port of the bias RAM wrapper. It then arbitrates the read side, serving one 8-channel bias vector (256 bits) per request to the convolution output stage. It sits between the DMA stream demux and the bias RAM; the RAM wrapper itself is instantiated at the parent level.

## Interface
Parameters:
- AXI_WIDTH, 64, stream/write-port data width.
- CH_OUT_NUM, 8, output channels per read vector (32-bit bias each).
- ADDR_BITS, 9, write-port address width. Read-port address width is ADDR_BITS-1.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start_load  in  1  pulse; begin loading a layer's biases.
- cout_num  in  16  output channels of the layer; sampled on start_load.
- s_data  in  AXI_WIDTH  bias stream data, two 32-bit biases per word, low half first.
- s_valid  in  1  stream valid.
- s_ready  out  1  stream ready.
- rd_req  in  1  request one bias vector.
- rd_group  in  ADDR_BITS-1  output-channel group index (channels 8*g..8*g+7).
- bias_valid  out  1  bias RAM doutb is valid this cycle.
- load_done  out  1  level; bias buffer loaded and readable.
- cfg_err  out  1  sticky; cout_num exceeded capacity.
- rd_err  out  1  one-cycle pulse; rejected read.
- ram_wr_en  out  1  to RAM wea.
- ram_wr_addr  out  ADDR_BITS  to RAM addra.
- ram_wr_data  out  AXI_WIDTH  to RAM dina.
- ram_rd_addr  out  ADDR_BITS-1  to RAM addrb.

## Operation
- States: IDLE, LOAD, DRAIN, READY.
- groups = ceil(cout_num/8). words = groups*4. Upstream always supplies exactly `words` words; the last group is zero-padded by the DMA.
- Capacity is 2^ADDR_BITS words (128 groups). If cout_num > 1024, clamp groups to 128, set cfg_err, and load normally. cfg_err clears only on rst or the next start_load with a legal cout_num.
- cout_num = 0: groups = 0; go IDLE→READY directly, with no stream accepted.
- IDLE/READY + start_load → LOAD. Word counter and load_done are cleared. In READY this discards the previous contents.
- start_load while in LOAD or DRAIN is ignored.
- LOAD: s_ready = 1. On each s_valid&s_ready, register data and address into ram_wr_*. Address = word counter, starting at 0. When the final word is accepted → DRAIN.
- DRAIN: one cycle. The final registered RAM write lands in this cycle. s_ready = 0. Then → READY.
- READY: load_done = 1. A rd_req with rd_group < groups drives ram_rd_addr = rd_group. A rd_req with rd_group ≥ groups pulses rd_err, issues no read, and leaves ram_rd_addr unchanged.
- rd_req outside READY: rd_err pulse, no read.
- Back-to-back rd_req every cycle is supported.

## Timing
- Reset values: state IDLE, s_ready 0, ram_wr_en 0, ram_wr_addr 0, ram_wr_data 0, ram_rd_addr 0, bias_valid 0, load_done 0, cfg_err 0, rd_err 0.
- s_ready is a registered output. It rises the cycle after start_load and falls the cycle after the final handshake.
- Write latency: handshake in cycle N → ram_wr_en = 1 in cycle N+1.
- ram_wr_en is high for exactly `words` cycles per load.
- load_done rises 2 cycles after the final handshake. This guarantees no read-during-write on the last address.
- Read latency: accepted rd_req in cycle N → ram_rd_addr registered in N+1 → bias_valid in N+2. This matches the RAM's one-cycle registered doutb.
- rd_err asserts in cycle N+1.
- rst mid-LOAD: go to IDLE next cycle with all outputs at reset values. Any partial RAM contents are invalid; load_done stays 0 until a full reload.

## Structure
- Shared package bias_ctrl_pkg:
  - state enum (IDLE/LOAD/DRAIN/READY);
  - constants BIAS_BITS = 32, RD_WORDS_PER_GROUP = 4, MAX_GROUPS = 2^(ADDR_BITS-2);
  - the group/word count helper function.
- No sub-module. The word counter, group compare and read-valid pipeline are too small to justify one.

## Test plan
- cout_num = 16, 8 words streamed with s_valid held high → 8 consecutive ram_wr_en at addresses 0..7; load_done high 2 cycles after the 8th handshake; rd_group 1 → bias_valid 2 cycles later with ram_rd_addr = 1.
- cout_num = 20 with s_valid toggling every other cycle → 12 writes, counter advances only on handshakes; rd_group 2 accepted; rd_group 3 → rd_err pulse and no bias_valid.
- cout_num = 2000 → cfg_err set; exactly 512 words accepted; s_ready drops after the 512th word; rd_group 127 is valid.
- rd_req every cycle for groups 0..3 in READY → four bias_valid pulses on consecutive cycles, with ram_rd_addr following 0,1,2,3 at a one-cycle lag.
- rst asserted after the 3rd of 8 words → next cycle IDLE with s_ready 0; a new start_load with cout_num = 8 → 4 writes from address 0, then load_done.
- cout_num = 0 → READY with no stream activity; any rd_req → rd_err.

Source files
------------

// File: rtl/bias_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bias_ctrl_pkg
// Shared types and constants for the bias buffer load/read sequencer.
//   state_t            : sequencer states (IDLE, LOAD, DRAIN, READY)
//   BIAS_BITS          : width of one bias value
//   RD_WORDS_PER_GROUP : 64-bit stream words per 8-channel bias vector
//   MAX_GROUPS         : bias vectors that fit the buffer at the default depth
//   calc_groups()      : ceil(cout_num / 8), the number of 8-channel groups
// -----------------------------------------------------------------------------
package bias_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

    localparam int BIAS_BITS          = 32;
    localparam int RD_WORDS_PER_GROUP = 4;
    localparam int DEF_ADDR_BITS      = 9;
    localparam int MAX_GROUPS         = 2 ** (DEF_ADDR_BITS - 2);

    // Number of 8-channel groups needed for cout_num channels, rounded up.
    // Computed one bit wider so cout_num = 16'hFFFF cannot wrap.
    function automatic logic [13:0] calc_groups(input logic [15:0] cout_num);
        logic [16:0] sum;
        sum = {1'b0, cout_num} + 17'd7;
        return sum[16:3];
    endfunction

endpackage

// File: rtl/bias_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// bias_load_ctrl_if
// Bundles the bias stream input, the read-request channel and the bias RAM
// write/read ports of bias_load_ctrl.
//   s_data/s_valid/s_ready : bias stream (two 32-bit biases per word, low first)
//   rd_req/rd_group        : request for one 8-channel bias vector
//   bias_valid             : RAM read data valid
//   ram_wr_en/addr/data    : RAM write port A
//   ram_rd_addr            : RAM read port B address
// Stream handshake: a word transfers on every rising clk edge where s_valid
// and s_ready are both high; s_data must be stable while s_valid is high and
// s_ready is low, and s_ready never depends combinationally on s_valid.
// Modports: master = stream source / read requester / RAM side,
//           slave  = the sequencer itself.
// -----------------------------------------------------------------------------
interface bias_load_ctrl_if #(
    parameter int AXI_WIDTH = 64,
    parameter int ADDR_BITS = 9
);
    logic [AXI_WIDTH-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    logic                 rd_req;
    logic [ADDR_BITS-2:0] rd_group;
    logic                 bias_valid;

    logic                 ram_wr_en;
    logic [ADDR_BITS-1:0] ram_wr_addr;
    logic [AXI_WIDTH-1:0] ram_wr_data;
    logic [ADDR_BITS-2:0] ram_rd_addr;

    modport master (
        output s_data, s_valid, rd_req, rd_group,
        input  s_ready, bias_valid, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
    );

    modport slave (
        input  s_data, s_valid, rd_req, rd_group,
        output s_ready, bias_valid, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
    );
endinterface

// File: rtl/bias_load_ctrl.sv
// -----------------------------------------------------------------------------
// bias_load_ctrl
// Loads a layer's biases from the AXI stream into the bias RAM write port,
// then serves one 8-channel bias vector per read request.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_load   : pulse, begin loading a layer (ignored while loading)
//   cout_num     : output channels of the layer, sampled on start_load
//   load_done    : level, buffer loaded and readable
//   cfg_err      : sticky, cout_num exceeded buffer capacity (groups clamped)
//   rd_err       : one-cycle pulse, read request rejected
//   dbg_state_o  : current sequencer state
//   bus          : stream, read request and RAM ports (slave modport)
// -----------------------------------------------------------------------------
module bias_load_ctrl
    import bias_ctrl_pkg::*;
#(
    parameter int AXI_WIDTH  = 64,
    parameter int CH_OUT_NUM = 8,
    parameter int ADDR_BITS  = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_load,
    input  logic [15:0]     cout_num,
    output logic            load_done,
    output logic            cfg_err,
    output logic            rd_err,
    output state_t          dbg_state_o,
    bias_load_ctrl_if.slave bus
);

    localparam int GRP_BITS        = ADDR_BITS - 1;   // holds 0..MAX_GRP inclusive
    localparam int CNT_BITS        = ADDR_BITS + 1;   // holds 0..2^ADDR_BITS inclusive
    localparam int MAX_GRP         = 2 ** (ADDR_BITS - 2);
    localparam int WORDS_PER_GROUP = (CH_OUT_NUM * BIAS_BITS) / AXI_WIDTH;

    state_t               state_q,     state_d;
    logic [CNT_BITS-1:0]  cnt_q,       cnt_d;
    logic [CNT_BITS-1:0]  words_q,     words_d;
    logic [GRP_BITS-1:0]  groups_q,    groups_d;
    logic                 s_ready_q,   s_ready_d;
    logic                 wr_en_q,     wr_en_d;
    logic [ADDR_BITS-1:0] wr_addr_q,   wr_addr_d;
    logic [AXI_WIDTH-1:0] wr_data_q,   wr_data_d;
    logic [GRP_BITS-1:0]  rd_addr_q,   rd_addr_d;
    logic                 rd_fire_q,   rd_fire_d;
    logic                 bias_vld_q;
    logic                 load_done_q, load_done_d;
    logic                 cfg_err_q,   cfg_err_d;
    logic                 rd_err_q,    rd_err_d;

    logic [13:0]          grp_raw;
    logic                 grp_over;
    logic [GRP_BITS-1:0]  grp_clamped;
    logic [CNT_BITS-1:0]  grp_words;
    logic                 handshake;
    logic                 last_word;
    logic                 rd_hit;

    // Group count for the cout_num presented with start_load; anything beyond
    // the buffer depth is clamped and flagged, and the load proceeds.
    assign grp_raw     = calc_groups(cout_num);
    assign grp_over    = (grp_raw > 14'(MAX_GRP));
    assign grp_clamped = grp_over ? GRP_BITS'(MAX_GRP) : grp_raw[GRP_BITS-1:0];
    assign grp_words   = CNT_BITS'(grp_clamped) * CNT_BITS'(WORDS_PER_GROUP);

    // s_ready_q is only ever high in LOAD, so this is the accepted-word strobe.
    assign handshake = bus.s_valid && s_ready_q;
    assign last_word = (cnt_q == (words_q - CNT_BITS'(1)));
    assign rd_hit    = (bus.rd_group < groups_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        words_d     = words_q;
        groups_d    = groups_q;
        s_ready_d   = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        rd_fire_d   = 1'b0;
        load_done_d = load_done_q;
        cfg_err_d   = cfg_err_q;
        rd_err_d    = 1'b0;

        case (state_q)
            IDLE, READY: begin
                if (start_load) begin
                    groups_d    = grp_clamped;
                    words_d     = grp_words;
                    cfg_err_d   = grp_over;
                    cnt_d       = '0;
                    load_done_d = 1'b0;
                    if (grp_clamped == '0) begin
                        // Nothing to stream: the (empty) buffer is readable now.
                        state_d     = READY;
                        load_done_d = 1'b1;
                    end else begin
                        state_d   = LOAD;
                        s_ready_d = 1'b1;
                    end
                end
                if (bus.rd_req) begin
                    if ((state_q == READY) && rd_hit) begin
                        rd_addr_d = bus.rd_group;
                        rd_fire_d = 1'b1;
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end

            LOAD: begin
                s_ready_d = 1'b1;
                if (handshake) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_BITS-1:0];
                    wr_data_d = bus.s_data;
                    cnt_d     = cnt_q + CNT_BITS'(1);
                    if (last_word) begin
                        state_d   = DRAIN;
                        s_ready_d = 1'b0;
                    end
                end
                rd_err_d = bus.rd_req;
            end

            DRAIN: begin
                // The final write is on the RAM port this cycle; load_done is
                // raised one cycle later so no read can hit that address early.
                state_d     = READY;
                load_done_d = 1'b1;
                rd_err_d    = bus.rd_req;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            words_q     <= '0;
            groups_q    <= '0;
            s_ready_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            rd_fire_q   <= 1'b0;
            bias_vld_q  <= 1'b0;
            load_done_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
            groups_q    <= groups_d;
            s_ready_q   <= s_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            rd_fire_q   <= rd_fire_d;
            // The RAM registers doutb, so data is valid one cycle after addrb.
            bias_vld_q  <= rd_fire_q;
            load_done_q <= load_done_d;
            cfg_err_q   <= cfg_err_d;
            rd_err_q    <= rd_err_d;
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.ram_wr_en   = wr_en_q;
    assign bus.ram_wr_addr = wr_addr_q;
    assign bus.ram_wr_data = wr_data_q;
    assign bus.ram_rd_addr = rd_addr_q;
    assign bus.bias_valid  = bias_vld_q;
    assign load_done       = load_done_q;
    assign cfg_err         = cfg_err_q;
    assign rd_err          = rd_err_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_bias_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bias_load_ctrl
// Directed and randomized checks of bias_load_ctrl against a behavioural model
// of the load/read rules (group counts, clamping, write sequence, read timing).
// -----------------------------------------------------------------------------
module tb_bias_load_ctrl;
    import bias_ctrl_pkg::*;

    localparam int AXI_WIDTH = 64;
    localparam int ADDR_BITS = 9;
    localparam int W         = ADDR_BITS + AXI_WIDTH;   // {addr, data} per write

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_load = 1'b0;
    logic [15:0] cout_num = '0;
    logic        load_done;
    logic        cfg_err;
    logic        rd_err;
    state_t      dbg_state;

    always #5 clk = ~clk;

    bias_load_ctrl_if #(.AXI_WIDTH(AXI_WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();

    bias_load_ctrl #(
        .AXI_WIDTH (AXI_WIDTH),
        .CH_OUT_NUM(8),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_load (start_load),
        .cout_num   (cout_num),
        .load_done  (load_done),
        .cfg_err    (cfg_err),
        .rd_err     (rd_err),
        .dbg_state_o(dbg_state),
        .bus        (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_q[$];
    int           rd_list[$];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // behavioural model state
    int m_groups  = 0;
    bit m_cfg_err = 1'b0;
    bit m_ready   = 1'b0;
    int m_rd_addr = 0;

    // every RAM write seen on the port, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.ram_wr_en === 1'b1) act_q.push_back({bus.ram_wr_addr, bus.ram_wr_data});
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_rd(input int g);
        rd_list.push_back(g);
    endtask

    // Loads one layer. mode 0: s_valid held high, 1: toggling, 2: random with
    // a stray start_load mid-load. abort_after > 0 applies rst after that many
    // accepted words.
    task automatic do_load(input int cout, input int mode, input int abort_after);
        int words;
        int i;
        int cyc;
        int bad_rdy;
        int nbad;
        int fb;
        bit aborted;
        bit v;
        words   = 0;
        i       = 0;
        cyc     = 0;
        bad_rdy = 0;
        aborted = 1'b0;

        m_cfg_err = (cout > 1024);
        m_groups  = m_cfg_err ? MAX_GROUPS : (cout + 7) / 8;
        m_ready   = 1'b0;
        words     = m_groups * RD_WORDS_PER_GROUP;
        exp_q.delete();
        act_q.delete();

        start_load = 1'b1;
        cout_num   = 16'(cout);
        step();
        start_load = 1'b0;
        chk("cfg_err_at_start", cfg_err, m_cfg_err);

        if (words == 0) begin
            m_ready = 1'b1;
            chk("zero_state_ready", dbg_state, READY);
            chk("zero_load_done", load_done, 1'b1);
            chk("zero_s_ready", bus.s_ready, 1'b0);
            repeat (3) step();
            chk("zero_no_writes", act_q.size(), 0);
            return;
        end

        chk("load_state", dbg_state, LOAD);
        chk("s_ready_rise", bus.s_ready, 1'b1);
        chk("load_done_clr", load_done, 1'b0);

        while (i < words && !aborted && cyc < 4000) begin
            if (bus.s_ready !== 1'b1) bad_rdy++;
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else                v = ($urandom_range(0, 3) != 0);
            bus.s_valid = v;
            bus.s_data  = {$urandom, $urandom};
            if (mode == 2 && cyc == 3) begin
                start_load = 1'b1;
                cout_num   = 16'($urandom_range(1, 2000));
            end
            if (v) exp_q.push_back({9'(i), bus.s_data});
            step();
            start_load = 1'b0;
            cyc++;
            if (v) begin
                i++;
                if (abort_after > 0 && i == abort_after) aborted = 1'b1;
            end
        end
        bus.s_valid = 1'b0;
        chk("load_cycle_budget", (cyc < 4000), 1'b1);

        if (aborted) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            m_cfg_err = 1'b0;
            m_rd_addr = 0;
            m_groups  = 0;
            chk("abort_state_idle", dbg_state, IDLE);
            chk("abort_s_ready", bus.s_ready, 1'b0);
            chk("abort_wr_en", bus.ram_wr_en, 1'b0);
            chk("abort_wr_addr", bus.ram_wr_addr, 0);
            chk("abort_wr_data", bus.ram_wr_data, 0);
            chk("abort_load_done", load_done, 1'b0);
            chk("abort_cfg_err", cfg_err, 1'b0);
            step();
            chk("abort_stays_idle", dbg_state, IDLE);
        end else begin
            chk("s_ready_fall", bus.s_ready, 1'b0);
            chk("last_wr_en", bus.ram_wr_en, 1'b1);
            chk("drain_no_done", load_done, 1'b0);
            step();
            chk("load_done_rise", load_done, 1'b1);
            chk("state_ready", dbg_state, READY);
            chk("wr_en_off", bus.ram_wr_en, 1'b0);
            chk("cfg_err_hold", cfg_err, m_cfg_err);
            m_ready = 1'b1;
        end

        chk("s_ready_in_load", bad_rdy, 0);
        chk("wr_count", act_q.size(), exp_q.size());
        nbad = 0;
        fb   = -1;
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            if (act_q[k] !== exp_q[k]) begin
                nbad++;
                if (fb < 0) fb = k;
            end
        end
        if (fb >= 0) $display("first write difference at index %0d: got %h want %h", fb, act_q[fb], exp_q[fb]);
        chk("wr_contents", nbad, 0);
    endtask

    // Issues the queued read requests back-to-back, one per cycle.
    task automatic do_reads();
        int n;
        bit acc[$];
        n = rd_list.size();
        for (int c = 0; c <= n; c++) begin
            bit a;
            a = 1'b0;
            if (c < n) begin
                bus.rd_req   = 1'b1;
                bus.rd_group = 8'(rd_list[c]);
                a = m_ready && (rd_list[c] < m_groups);
                acc.push_back(a);
            end else begin
                bus.rd_req = 1'b0;
            end
            step();
            if (a) m_rd_addr = rd_list[c];
            chk("rd_err", rd_err, (c < n) ? !a : 1'b0);
            chk("rd_addr", bus.ram_rd_addr, m_rd_addr);
            chk("bias_valid", bus.bias_valid, (c > 0) ? acc[c-1] : 1'b0);
        end
        bus.rd_req = 1'b0;
        rd_list.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.s_data   = '0;
        bus.s_valid  = 1'b0;
        bus.rd_req   = 1'b0;
        bus.rd_group = '0;

        rst = 1'b1;
        repeat (3) step();
        chk("rst_state", dbg_state, IDLE);
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_wr_en", bus.ram_wr_en, 1'b0);
        chk("rst_wr_addr", bus.ram_wr_addr, 0);
        chk("rst_wr_data", bus.ram_wr_data, 0);
        chk("rst_rd_addr", bus.ram_rd_addr, 0);
        chk("rst_bias_valid", bus.bias_valid, 1'b0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_rd_err", rd_err, 1'b0);
        rst = 1'b0;
        step();

        // read before any load is rejected
        add_rd(0);
        do_reads();

        // 16 channels, continuous stream
        do_load(16, 0, 0);
        add_rd(1);
        do_reads();

        // 20 channels, stream valid every other cycle
        do_load(20, 1, 0);
        add_rd(2);
        add_rd(3);
        do_reads();

        // over capacity: clamped to full buffer
        do_load(2000, 0, 0);
        add_rd(127);
        add_rd(128);
        do_reads();
        for (int g = 0; g < 4; g++) add_rd(g);
        do_reads();

        // legal cout_num clears cfg_err; random valid and ignored start_load
        do_load(16, 2, 0);
        add_rd(0);
        add_rd(2);
        do_reads();

        // reset mid-load, then a full reload
        do_load(16, 0, 3);
        add_rd(0);
        do_reads();
        do_load(8, 0, 0);
        add_rd(0);
        add_rd(1);
        do_reads();

        // empty layer
        do_load(0, 0, 0);
        add_rd(0);
        add_rd(5);
        do_reads();

        // randomized layers
        repeat (3) begin
            do_load($urandom_range(1, 300), 2, 0);
            repeat (6) add_rd($urandom_range(0, m_groups + 2));
            do_reads();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
